// File: rtl/rob_pkg.sv
// Shared types and sizing for the reorder buffer; the issue queue imports rob_idx_t.
package rob_pkg;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned DEPTH  = 128;
  localparam int unsigned IDX_W  = 7;
  localparam int unsigned PREG_W = 8;
  localparam int unsigned CNT_W  = IDX_W + 1;
  localparam int unsigned CCNT_W = 3;

  typedef logic [IDX_W-1:0]  rob_idx_t;
  typedef logic [PREG_W-1:0] preg_t;

  typedef struct packed {
    logic  valid;
    logic  done;
    preg_t dest;
    preg_t old;
  } rob_entry_t;

endpackage

// File: rtl/rob_commit_select.sv
// Picks the in-order run of finished entries at the head window and formats the retire lanes.
module rob_commit_select
  import rob_pkg::*;
(
  input  logic [IDX_W-1:0]              head_i,
  input  rob_entry_t [WIDTH-1:0]        win_i,
  output logic [CCNT_W-1:0]             count_o,
  output logic [WIDTH-1:0][IDX_W-1:0]   idx_o,
  output logic [WIDTH-1:0][PREG_W-1:0]  dest_o,
  output logic [WIDTH-1:0][PREG_W-1:0]  old_o
);

  logic run;

  // Retirement stops at the first entry that is not both valid and done.
  always_comb begin
    count_o = '0;
    idx_o   = '0;
    dest_o  = '0;
    old_o   = '0;
    run     = 1'b1;
    for (int j = 0; j < WIDTH; j++) begin
      if (run && win_i[j].valid && win_i[j].done) begin
        idx_o[j]  = head_i + IDX_W'(j);
        dest_o[j] = win_i[j].dest;
        old_o[j]  = win_i[j].old;
        count_o   = count_o + CCNT_W'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob.sv
// 4-wide reorder buffer: in-order allocation at dispatch, out-of-order completion, in-order retire.
module rob
  import rob_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic [WIDTH-1:0]              dispatch_valid,
  input  logic [WIDTH-1:0][PREG_W-1:0]  dispatch_dest,
  input  logic [WIDTH-1:0][PREG_W-1:0]  dispatch_old,
  output logic [WIDTH-1:0][IDX_W-1:0]   alloc_idx,
  output logic                          full,
  input  logic [WIDTH-1:0]              complete_valid,
  input  logic [WIDTH-1:0][IDX_W-1:0]   complete_idx,
  output logic [CCNT_W-1:0]             commit_count,
  output logic [WIDTH-1:0][IDX_W-1:0]   commit_idx,
  output logic [WIDTH-1:0][PREG_W-1:0]  commit_dest,
  output logic [WIDTH-1:0][PREG_W-1:0]  commit_old,
  output logic [CNT_W-1:0]              count
);

  rob_entry_t            entries_q [DEPTH];
  rob_entry_t            entries_d [DEPTH];
  rob_idx_t              head_q, head_d;
  rob_idx_t              tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CCNT_W-1:0]     disp_n;
  rob_idx_t              acc;
  rob_entry_t [WIDTH-1:0] win;

  assign full  = count_q > CNT_W'(DEPTH - WIDTH);
  assign count = count_q;

  // Compacted allocation: each lane gets tail plus the number of valid lanes below it.
  always_comb begin
    acc    = tail_q;
    disp_n = '0;
    for (int k = 0; k < WIDTH; k++) begin
      alloc_idx[k] = acc;
      acc          = acc + IDX_W'(dispatch_valid[k]);
      disp_n       = disp_n + CCNT_W'(dispatch_valid[k]);
    end
  end

  always_comb begin
    for (int j = 0; j < WIDTH; j++) begin
      win[j] = entries_q[head_q + IDX_W'(j)];
    end
  end

  rob_commit_select u_commit_select (
    .head_i  (head_q),
    .win_i   (win),
    .count_o (commit_count),
    .idx_o   (commit_idx),
    .dest_o  (commit_dest),
    .old_o   (commit_old)
  );

  // Retire clears are applied last so they override a redundant same-cycle completion.
  always_comb begin
    entries_d = entries_q;
    if (!full) begin
      for (int k = 0; k < WIDTH; k++) begin
        if (dispatch_valid[k]) begin
          entries_d[alloc_idx[k]] = '{valid: 1'b1, done: 1'b0,
                                      dest: dispatch_dest[k], old: dispatch_old[k]};
        end
      end
    end
    for (int k = 0; k < WIDTH; k++) begin
      if (complete_valid[k] && entries_q[complete_idx[k]].valid) begin
        entries_d[complete_idx[k]].done = 1'b1;
      end
    end
    for (int j = 0; j < WIDTH; j++) begin
      if (CCNT_W'(j) < commit_count) begin
        entries_d[commit_idx[j]].valid = 1'b0;
        entries_d[commit_idx[j]].done  = 1'b0;
      end
    end
    head_d  = head_q + IDX_W'(commit_count);
    tail_d  = full ? tail_q : tail_q + IDX_W'(disp_n);
    count_d = count_q + (full ? '0 : CNT_W'(disp_n)) - CNT_W'(commit_count);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

endmodule

// File: tb/tb_rob.sv
// Directed bench for the reorder buffer: allocation, completion/retire ordering, full, wrap, reset.
module tb_rob;
  import rob_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [3:0]            dispatch_valid;
  logic [3:0][7:0]       dispatch_dest, dispatch_old;
  logic [3:0][6:0]       alloc_idx;
  logic                  full;
  logic [3:0]            complete_valid;
  logic [3:0][6:0]       complete_idx;
  logic [2:0]            commit_count;
  logic [3:0][6:0]       commit_idx;
  logic [3:0][7:0]       commit_dest, commit_old;
  logic [7:0]            count;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0][6:0] prev_idx, cur_idx;
  logic [3:0]      prev_mask;
  logic [6:0]      tail_m;

  always #5 clk = ~clk;

  rob dut (
    .clk            (clk),
    .reset          (reset),
    .dispatch_valid (dispatch_valid),
    .dispatch_dest  (dispatch_dest),
    .dispatch_old   (dispatch_old),
    .alloc_idx      (alloc_idx),
    .full           (full),
    .complete_valid (complete_valid),
    .complete_idx   (complete_idx),
    .commit_count   (commit_count),
    .commit_idx     (commit_idx),
    .commit_dest    (commit_dest),
    .commit_old     (commit_old),
    .count          (count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    dispatch_valid = '0;
    complete_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    idle();
    complete_idx   = '0;
    dispatch_valid = 4'hF;
    for (int k = 0; k < 4; k++) begin
      dispatch_dest[k] = 8'(10 + k);
      dispatch_old[k]  = 8'(20 + k);
    end
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_full", 32'(full), 0);
    check("rst_commit_count", 32'(commit_count), 0);
    check("rst_commit_idx0", 32'(commit_idx[0]), 0);
    check("rst_commit_old0", 32'(commit_old[0]), 0);
    for (int k = 0; k < 4; k++) check("rst_alloc", 32'(alloc_idx[k]), 32'(k));
    #1 reset = 1'b1;
    #1 check("first_alloc3", 32'(alloc_idx[3]), 3);
    tick(); idle(); #1;
    check("d1_count", 32'(count), 4);
    check("d1_commit_count", 32'(commit_count), 0);
    check("d1_tail", 32'(alloc_idx[0]), 4);

    // Sparse dispatch compacts onto consecutive indices.
    dispatch_valid = 4'b1010;
    dispatch_dest[1] = 8'd30; dispatch_old[1] = 8'd40;
    dispatch_dest[3] = 8'd31; dispatch_old[3] = 8'd41;
    #1;
    check("sparse_alloc1", 32'(alloc_idx[1]), 4);
    check("sparse_alloc3", 32'(alloc_idx[3]), 5);
    tick(); idle(); #1;
    check("sparse_count", 32'(count), 6);
    check("sparse_tail", 32'(alloc_idx[0]), 6);

    // Out-of-order completion, in-order retire with one-cycle latency.
    complete_valid = 4'b0011; complete_idx[0] = 7'd2; complete_idx[1] = 7'd0;
    #1 check("cpl_same_cycle", 32'(commit_count), 0);
    tick();
    complete_valid = 4'b0001; complete_idx[0] = 7'd1;
    #1;
    check("c1_count", 32'(commit_count), 1);
    check("c1_idx0", 32'(commit_idx[0]), 0);
    check("c1_dest0", 32'(commit_dest[0]), 10);
    check("c1_old0", 32'(commit_old[0]), 20);
    check("c1_idx1_zero", 32'(commit_idx[1]), 0);
    check("c1_old1_zero", 32'(commit_old[1]), 0);
    tick(); idle(); #1;
    check("c2_count", 32'(commit_count), 2);
    check("c2_idx0", 32'(commit_idx[0]), 1);
    check("c2_idx1", 32'(commit_idx[1]), 2);
    check("c2_old1", 32'(commit_old[1]), 22);
    check("c2_occupancy", 32'(count), 5);
    tick(); #1;
    check("c2_after_count", 32'(count), 3);
    check("c2_after_commit", 32'(commit_count), 0);

    // Lane 3 targets an unallocated entry and must have no effect.
    complete_valid = 4'hF;
    complete_idx[0] = 7'd3; complete_idx[1] = 7'd4;
    complete_idx[2] = 7'd5; complete_idx[3] = 7'd50;
    tick(); idle(); #1;
    check("c3_count", 32'(commit_count), 3);
    check("c3_idx2", 32'(commit_idx[2]), 5);
    check("c3_old2", 32'(commit_old[2]), 41);
    check("c3_dest1", 32'(commit_dest[1]), 30);
    check("c3_idx3_zero", 32'(commit_idx[3]), 0);
    tick(); #1;
    check("empty_count", 32'(count), 0);
    check("empty_commit", 32'(commit_count), 0);
    check("empty_head_eq_tail", 32'(alloc_idx[0]), 6);

    // Fill to the full threshold.
    for (int c = 0; c < 31; c++) begin
      dispatch_valid = 4'hF;
      for (int k = 0; k < 4; k++) begin
        dispatch_dest[k] = 8'hA0;
        dispatch_old[k]  = 8'(c * 4 + k);
      end
      tick();
    end
    idle(); #1;
    check("fill124_count", 32'(count), 124);
    check("fill124_full", 32'(full), 0);
    dispatch_valid = 4'b0001; dispatch_old[0] = 8'd124;
    tick(); idle(); #1;
    check("fill125_count", 32'(count), 125);
    check("fill125_full", 32'(full), 1);
    dispatch_valid = 4'hF;
    #1 check("full_tail", 32'(alloc_idx[0]), 3);
    tick();
    complete_valid = 4'hF;
    for (int k = 0; k < 4; k++) complete_idx[k] = 7'(6 + k);
    #1 check("full_ignored_count", 32'(count), 125);
    tick(); complete_valid = '0; #1;
    check("full_commit_count", 32'(commit_count), 4);
    check("full_commit_idx0", 32'(commit_idx[0]), 6);
    check("full_commit_old3", 32'(commit_old[3]), 3);
    check("full_not_relieved", 32'(full), 1);
    tick(); #1;
    check("relieved_count", 32'(count), 121);
    check("relieved_full", 32'(full), 0);
    check("relieved_tail", 32'(alloc_idx[0]), 3);
    tick(); idle(); #1;
    check("refill_count", 32'(count), 125);
    check("refill_tail", 32'(alloc_idx[0]), 7);

    reset = 1'b0;
    #1 check("reset_full_buf", 32'(count), 0);
    reset = 1'b1;
    tick();

    // Walk tail/head to 126 with a dispatch/complete pipeline.
    dispatch_valid = 4'b0011;
    tick();
    prev_mask = 4'b0011; prev_idx = '0; prev_idx[1] = 7'd1; tail_m = 7'd2;
    for (int c = 0; c < 31; c++) begin
      dispatch_valid = 4'hF;
      for (int k = 0; k < 4; k++) cur_idx[k] = tail_m + 7'(k);
      complete_valid = prev_mask;
      complete_idx   = prev_idx;
      tick();
      prev_idx  = cur_idx;
      prev_mask = 4'hF;
      tail_m    = tail_m + 7'd4;
    end
    dispatch_valid = '0;
    complete_valid = prev_mask;
    complete_idx   = prev_idx;
    tick();
    complete_valid = '0;
    for (int i = 0; i < 40 && count != 0; i++) tick();
    check("walk_drained", 32'(count), 0);
    check("walk_tail", 32'(alloc_idx[0]), 126);

    dispatch_valid = 4'hF;
    for (int k = 0; k < 4; k++) begin
      dispatch_dest[k] = 8'(50 + k);
      dispatch_old[k]  = 8'(60 + k);
    end
    #1;
    check("wrap_alloc0", 32'(alloc_idx[0]), 126);
    check("wrap_alloc1", 32'(alloc_idx[1]), 127);
    check("wrap_alloc2", 32'(alloc_idx[2]), 0);
    check("wrap_alloc3", 32'(alloc_idx[3]), 1);
    tick(); idle();
    complete_valid = 4'hF;
    complete_idx[0] = 7'd126; complete_idx[1] = 7'd127;
    complete_idx[2] = 7'd0;   complete_idx[3] = 7'd1;
    tick(); complete_valid = '0; #1;
    check("wrap_commit_count", 32'(commit_count), 4);
    check("wrap_commit_idx0", 32'(commit_idx[0]), 126);
    check("wrap_commit_idx1", 32'(commit_idx[1]), 127);
    check("wrap_commit_idx2", 32'(commit_idx[2]), 0);
    check("wrap_commit_idx3", 32'(commit_idx[3]), 1);
    check("wrap_commit_old3", 32'(commit_old[3]), 63);
    check("wrap_commit_dest0", 32'(commit_dest[0]), 50);
    tick(); #1;
    check("wrap_after_count", 32'(count), 0);
    check("wrap_head", 32'(alloc_idx[0]), 2);

    // Mid-stream asynchronous reset with ten entries pending.
    dispatch_valid = 4'hF; tick();
    tick();
    dispatch_valid = 4'b0011; tick();
    idle(); #1;
    check("pre_reset_count", 32'(count), 10);
    complete_valid = 4'b0011; complete_idx[0] = 7'd2; complete_idx[1] = 7'd3;
    tick(); idle(); #1;
    check("pre_reset_commit", 32'(commit_count), 2);
    reset = 1'b0;
    #1;
    check("async_rst_count", 32'(count), 0);
    check("async_rst_full", 32'(full), 0);
    check("async_rst_commit", 32'(commit_count), 0);
    check("async_rst_commit_idx1", 32'(commit_idx[1]), 0);
    reset = 1'b1;
    tick();
    dispatch_valid = 4'hF;
    #1;
    check("post_rst_alloc0", 32'(alloc_idx[0]), 0);
    check("post_rst_alloc3", 32'(alloc_idx[3]), 3);
    tick(); idle(); #1;
    check("post_rst_count", 32'(count), 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
